cu_read_command_credit_buffer: RTL
==================================

Name: cu_read_command_credit_buffer

Overview:
- Sits directly downstream of the compute-unit control stage's `read_command_out` and upstream of the AFU command arbiter.
- Buffers read commands in a FIFO and issues them only while read credits remain.
- Tracks outstanding reads and returns a credit per `read_response_in`.
- Drives `BufferStatus` back to the control stage's `read_buffer_status` input as backpressure.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4.
- CREDITS, 32, max outstanding read commands; ≥1.
- ALMOST_FULL_LEVEL, 12, occupancy at or above which `alfull` asserts; <DEPTH.

Ports:
- clock  input  1  single clock, all logic on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- enabled_in  input  1  global enable; gates issue only.
- read_command_in  input  CommandBufferLine  command from control stage; one per cycle when valid.
- read_response_in  input  ResponseBufferLine  read completion; valid returns one credit.
- command_ready_in  input  1  arbiter accepts an issued command this cycle.
- read_command_out  output  CommandBufferLine  issued command, registered.
- read_buffer_status_out  output  BufferStatus  full/alfull/empty/valid of the FIFO, registered.
- outstanding_count_out  output  $clog2(CREDITS+1)  reads issued but not yet responded.
- overflow_error_out  output  1  sticky: push attempted while full.
- credit_error_out  output  1  sticky: response received with zero outstanding.

Behaviour:
Reset (`rst_in`=1 at a clock edge):
- FIFO is emptied and pointers go to 0; FSM goes to IDLE.
- Outputs: `read_command_out.valid`=0, payload 0; status `empty`=1, `full`=0, `alfull`=0, `valid`=0; `outstanding_count_out`=0; both error flags 0.
- Reset mid-operation discards buffered and in-flight bookkeeping. Responses arriving afterwards raise `credit_error_out`.

FIFO:
- Pointers are log2(DEPTH)+1 bits; the MSB disambiguates full from empty. Wrap is natural modulo 2·DEPTH.
- Push when `read_command_in.valid` && !full.
- Push while full: the command is dropped, `overflow_error_out` is set, the pointer is unchanged.
- Simultaneous push and pop at full: the pop frees a slot, but the push is still rejected because full is evaluated before the pop.
- Simultaneous push and pop at empty: not possible, since a command pushed at cycle N is first visible at cycle N+1.

Issue condition (`can_issue`):
- FSM in RUN && !empty && outstanding<CREDITS && `command_ready_in`.
- On issue, the head is popped and `read_command_out` is registered next cycle with valid=1 for exactly one cycle per command.
- Latency: push at edge N, earliest `read_command_out.valid` at edge N+2 (FIFO write at N, issue decision at N+1).

Credits:
- Issue increments the outstanding count; `read_response_in.valid` decrements it.
- Issue and response in the same cycle: net unchanged.
- Response at outstanding=0: count stays 0, `credit_error_out` is set.
- The count never exceeds CREDITS.

FSM:
- IDLE: `enabled_in`=0; accepts pushes, no issue. Goes to RUN when `enabled_in`=1.
- RUN: issues per `can_issue`. Goes to THROTTLE when outstanding reaches CREDITS, including the cycle an issue makes it reach CREDITS. Goes to IDLE when `enabled_in`=0, which takes priority.
- THROTTLE: no issue. Goes back to RUN on any response that decrements the count. Goes to IDLE when `enabled_in`=0.
- Responses are counted in all states.

Status:
- `full`: occupancy==DEPTH.
- `alfull`: occupancy≥ALMOST_FULL_LEVEL.
- `empty`: occupancy==0.
- `valid`: !empty.
- All are registered from post-update occupancy, so status lags the pointers by one cycle. ALMOST_FULL_LEVEL must leave ≥2 slots of margin for the upstream pipeline.

Decomposition:
- Shared CU package (already holding CommandBufferLine, ResponseBufferLine, BufferStatus):
  - add the enum `read_credit_state` {IDLE, RUN, THROTTLE};
  - add the constants `READ_CMD_BUFFER_DEPTH`=16 and `READ_CMD_CREDITS`=32 as the defaults.
- One sub-module: `cu_command_fifo`, a parameterised synchronous FIFO of CommandBufferLine payloads with push/pop, occupancy and full/empty outputs.
- Credit counter, FSM and output registers stay in the top.

Test Plan:
- Reset then idle → all outputs at reset values; status `empty`=1; no `read_command_out.valid` for 20 cycles.
- `enabled_in`=1, `command_ready_in`=1, push 3 commands with tags 1,2,3 on consecutive cycles → valid at edges N+2, N+3, N+4 in order 1,2,3; `outstanding_count_out`=3.
- CREDITS=4, no responses, push 6 → exactly 4 issued, FSM in THROTTLE, occupancy 2. One response → 5th issued; `outstanding_count_out` stays 4.
- `command_ready_in`=0, push 17 commands with DEPTH=16 → `alfull` at 12, `full` at 16, 17th dropped, `overflow_error_out`=1 and sticky.
- Response with outstanding=0 → `credit_error_out`=1, count stays 0. Same-cycle issue plus response at count 2 → count stays 2.
- Reset asserted with 5 buffered and 3 outstanding → next cycle `empty`=1, count 0, `read_command_out.valid`=0.

Source files
------------

// File: rtl/cu_read_command_credit_buffer_pkg.sv
// Shared compute-unit types for the read-command path plus the credit buffer defaults.
package cu_read_command_credit_buffer_pkg;

  localparam int unsigned READ_CMD_BUFFER_DEPTH = 16;
  localparam int unsigned READ_CMD_CREDITS      = 32;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic [31:0] address;
  } CommandBufferLine;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
  } ResponseBufferLine;

  typedef struct packed {
    logic full;
    logic alfull;
    logic empty;
    logic valid;
  } BufferStatus;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    THROTTLE = 2'd2
  } read_credit_state;

endpackage

// File: rtl/cu_command_fifo.sv
// Synchronous FIFO of CommandBufferLine payloads with an extra pointer bit for full/empty.
module cu_command_fifo
  import cu_read_command_credit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = READ_CMD_BUFFER_DEPTH
) (
  input  logic                   clock,
  input  logic                   rst_in,
  input  logic                   push,
  input  CommandBufferLine       push_data,
  input  logic                   pop,
  output CommandBufferLine       head,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  CommandBufferLine mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign occupancy = wr_ptr - rd_ptr;
  assign head      = mem[rd_ptr[AW-1:0]];

  // full is judged before this cycle's pop, so a push at full is refused even when a pop frees a slot
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clock) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/cu_read_command_credit_buffer.sv
// Buffers read commands and issues them to the AFU arbiter while read credits remain.
module cu_read_command_credit_buffer
  import cu_read_command_credit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH             = READ_CMD_BUFFER_DEPTH,
  parameter int unsigned CREDITS           = READ_CMD_CREDITS,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input  logic                           clock,
  input  logic                           rst_in,
  input  logic                           enabled_in,
  input  CommandBufferLine               read_command_in,
  input  ResponseBufferLine              read_response_in,
  input  logic                           command_ready_in,
  output CommandBufferLine               read_command_out,
  output BufferStatus                    read_buffer_status_out,
  output logic [$clog2(CREDITS+1)-1:0]   outstanding_count_out,
  output logic                           overflow_error_out,
  output logic                           credit_error_out
);

  localparam int unsigned OCW = $clog2(DEPTH) + 1;
  localparam int unsigned CW  = $clog2(CREDITS + 1);
  localparam logic [OCW-1:0] OCC_FULL   = OCW'(DEPTH);
  localparam logic [OCW-1:0] OCC_ALFULL = OCW'(ALMOST_FULL_LEVEL);
  localparam logic [OCW-1:0] OCC_ONE    = OCW'(1);
  localparam logic [CW-1:0]  CRED_MAX   = CW'(CREDITS);
  localparam logic [CW-1:0]  CRED_ONE   = CW'(1);

  read_credit_state state;
  CommandBufferLine head;
  logic [OCW-1:0]   occupancy;
  logic [OCW-1:0]   occupancy_next;
  logic [CW-1:0]    outstanding_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_ok;
  logic             can_issue;
  logic             resp_ok;
  logic             unused_response_tag;

  assign unused_response_tag = ^read_response_in.tag;

  cu_command_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .rst_in    (rst_in),
    .push      (read_command_in.valid),
    .push_data (read_command_in),
    .pop       (can_issue),
    .head      (head),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign push_ok   = read_command_in.valid && !fifo_full;
  assign can_issue = (state == RUN) && !fifo_empty && (outstanding_count_out < CRED_MAX)
                     && command_ready_in;
  assign resp_ok   = read_response_in.valid && (outstanding_count_out != '0);

  always_comb begin
    occupancy_next = occupancy;
    if (push_ok)   occupancy_next = occupancy_next + OCC_ONE;
    if (can_issue) occupancy_next = occupancy_next - OCC_ONE;
    outstanding_next = outstanding_count_out;
    if (can_issue) outstanding_next = outstanding_next + CRED_ONE;
    if (resp_ok)   outstanding_next = outstanding_next - CRED_ONE;
  end

  always_ff @(posedge clock) begin
    if (rst_in) begin
      state                  <= IDLE;
      read_command_out       <= '0;
      read_buffer_status_out <= '{full: 1'b0, alfull: 1'b0, empty: 1'b1, valid: 1'b0};
      outstanding_count_out  <= '0;
      overflow_error_out     <= 1'b0;
      credit_error_out       <= 1'b0;
    end else begin
      read_command_out <= '0;
      if (can_issue) begin
        read_command_out       <= head;
        read_command_out.valid <= 1'b1;
      end

      read_buffer_status_out.full   <= (occupancy_next == OCC_FULL);
      read_buffer_status_out.alfull <= (occupancy_next >= OCC_ALFULL);
      read_buffer_status_out.empty  <= (occupancy_next == '0);
      read_buffer_status_out.valid  <= (occupancy_next != '0);

      outstanding_count_out <= outstanding_next;

      if (read_command_in.valid && fifo_full) overflow_error_out <= 1'b1;
      if (read_response_in.valid && (outstanding_count_out == '0)) credit_error_out <= 1'b1;

      // disable wins over credit-driven moves in RUN and THROTTLE
      case (state)
        IDLE:     if (enabled_in) state <= RUN;
        RUN:      if (!enabled_in) state <= IDLE;
                  else if (outstanding_next == CRED_MAX) state <= THROTTLE;
        THROTTLE: if (!enabled_in) state <= IDLE;
                  else if (resp_ok) state <= RUN;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
